// File: rtl/lsb_first_serializer.sv
//------------------------------------------------------------------------------
// Module      : lsb_first_serializer
// Description : Parallel-to-serial converter, LSB first, with a one-cycle
//               frame_start pulse ahead of every word for a downstream
//               serial two's complementer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsb_first_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_last;
    logic             w_hs;

    assign w_last      = (state_q == SHIFT) && (count_q == LAST);
    // Reset gates ready so a word offered during reset is never taken.
    assign in_ready    = !areset && ((state_q == IDLE) || w_last);
    assign w_hs        = in_valid && in_ready;

    assign x_valid     = (state_q == SHIFT);
    assign x           = (state_q == SHIFT) && shreg_q[0];
    assign frame_start = (state_q == CLEAR);
    assign busy        = (state_q == CLEAR) || (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    state_d = CLEAR;
                    shreg_d = in_data;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                count_d = '0;
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                count_d = count_q + CW'(1);
                if (w_last) begin
                    count_d = '0;
                    if (w_hs) begin
                        state_d = CLEAR;
                        shreg_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsb_first_serializer.sv
//------------------------------------------------------------------------------
// Module      : tb_lsb_first_serializer
// Description : Directed self-checking bench for lsb_first_serializer (WIDTH=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsb_first_serializer;

    logic       clk = 1'b0;
    logic       areset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       x;
    logic       x_valid;
    logic       frame_start;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Downstream serial two's complementer: pass bits up to and including
    // the first 1, invert everything after it.
    logic seen_q;
    logic y;
    assign y = x ^ seen_q;
    always @(posedge clk) begin
        if (frame_start)      seen_q <= 1'b0;
        else if (x_valid && x) seen_q <= 1'b1;
    end

    lsb_first_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " x"},           32'(x),           0);
        chk({tag, " x_valid"},     32'(x_valid),     0);
        chk({tag, " frame_start"}, 32'(frame_start), 0);
        chk({tag, " busy"},        32'(busy),        0);
        chk({tag, " in_ready"},    32'(in_ready),    1);
    endtask

    // Offer a word while in_ready is high and step into the CLEAR cycle.
    task automatic start(input logic [7:0] w, input string tag);
        in_data  = w;
        in_valid = 1'b1;
        chk({tag, " ready@hs"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the CLEAR cycle; leaves inputs set for the edge ending the
    // last bit cycle, without taking that edge.
    task automatic serialize(input logic [7:0] w, input bit noise, input bit chain,
                             input logic [7:0] nxt, input string tag);
        chk({tag, " clr frame_start"}, 32'(frame_start), 1);
        chk({tag, " clr x_valid"},     32'(x_valid),     0);
        chk({tag, " clr x"},           32'(x),           0);
        chk({tag, " clr busy"},        32'(busy),        1);
        chk({tag, " clr in_ready"},    32'(in_ready),    0);
        in_valid = noise;
        in_data  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s bit%0d x", tag, i),        32'(x),           32'(w[i]));
            chk($sformatf("%s bit%0d x_valid", tag, i),  32'(x_valid),     1);
            chk($sformatf("%s bit%0d fs", tag, i),       32'(frame_start), 0);
            chk($sformatf("%s bit%0d busy", tag, i),     32'(busy),        1);
            chk($sformatf("%s bit%0d in_ready", tag, i), 32'(in_ready),    32'(i == 7));
            if (i == 7) begin
                in_valid = chain;
                in_data  = nxt;
            end else begin
                in_valid = noise;
                in_data  = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] comp_exp;
        areset   = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        chk("rst in_ready", 32'(in_ready), 0);
        areset = 1'b0;
        #1;
        check_idle("after rst");

        // Single word
        start(8'h01, "single");
        serialize(8'h01, 1'b0, 1'b0, 8'h00, "single");
        tick();
        check_idle("single end");

        // Back-to-back words
        start(8'hA5, "b2b0");
        serialize(8'hA5, 1'b0, 1'b1, 8'h3C, "b2b0");
        tick();
        serialize(8'h3C, 1'b0, 1'b0, 8'h00, "b2b1");
        tick();
        check_idle("b2b end");

        // in_valid held with changing data while shifting
        start(8'hF0, "noise");
        serialize(8'hF0, 1'b1, 1'b1, 8'h81, "noise");
        tick();
        serialize(8'h81, 1'b0, 1'b0, 8'h00, "after noise");
        tick();
        check_idle("noise end");

        // Reset in the middle of a word
        start(8'hFF, "midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst bit%0d x", i), 32'(x), 1);
        end
        areset   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h12;
        #1;
        chk("midrst ready in rst", 32'(in_ready), 0);
        tick();
        areset   = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("midrst after");
        start(8'h80, "post rst");
        serialize(8'h80, 1'b0, 1'b0, 8'h00, "post rst");
        tick();
        check_idle("post rst end");

        // Reset and handshake attempt on the same edge
        areset   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        chk("rst vs hs ready", 32'(in_ready), 0);
        tick();
        areset   = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("rst vs hs");
        tick();
        check_idle("rst vs hs +1");

        // End-to-end with the complementer: 0x06 -> 0xFA
        comp_exp = 8'hFA;
        start(8'h06, "comp");
        chk("comp frame_start", 32'(frame_start), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("comp y%0d", i), 32'(y), 32'(comp_exp[i]));
        end
        tick();
        check_idle("comp end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsb_first_serializer.md
LSB_FIRST_SERIALIZER -- requirements
Module: lsb_first_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port x  output  1  serial bit to the downstream two's complementer, LSB first.
REQ-008 SHALL have port x_valid  output  1  x carries a word bit this cycle.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse that clears the downstream complementer state before a new word.
REQ-010 SHALL have port busy  output  1  a word is in flight (CLEAR or SHIFT state).

Function
REQ-011 SHALL implement the FSM states IDLE, CLEAR and SHIFT, plus a WIDTH-bit shift register and a bit counter of clog2(WIDTH) bits.
REQ-012 SHALL capture in_data into the shift register on a rising edge where in_valid=1 and in_ready=1 (the handshake).
REQ-013 SHALL drive in_ready=1 in IDLE, and in SHIFT only on the last bit cycle (count = WIDTH-1), and 0 otherwise.
REQ-014 SHALL transition IDLE->CLEAR on handshake, and SHALL stay in IDLE otherwise.
REQ-015 SHALL drive frame_start=1, x_valid=0 and x=0 for exactly the one cycle spent in CLEAR, then go to SHIFT with count=0.
REQ-016 SHALL, in SHIFT, drive x=shreg[0] and x_valid=1, shift the register right by one each cycle, and increment count.
REQ-017 SHALL, on the last SHIFT cycle, go to CLEAR if a handshake occurs that cycle, else to IDLE.
REQ-018 SHALL produce this latency: handshake at edge k -> frame_start high in cycle k+1 -> bit i on x in cycle k+2+i, for i = 0..WIDTH-1.
REQ-019 SHALL sustain back-to-back words at WIDTH+1 cycles per word, with no extra idle cycle.
REQ-020 SHALL ignore in_valid while in_ready=0; in_data SHALL NOT be sampled, and the word in flight SHALL NOT be disturbed.
REQ-021 SHALL drive busy=1 exactly when the state is CLEAR or SHIFT.
REQ-022 SHALL drive x=0 and x_valid=0 in IDLE.
REQ-023 SHALL make all outputs functions of registered state only, with no combinational path from in_data to x.

Reset
REQ-024 SHALL, on a rising edge with areset=1, set state=IDLE, shreg=0 and count=0, with priority over any handshake that edge.
REQ-025 SHALL force in_ready=0 while areset=1, so no handshake completes during reset.
REQ-026 SHALL hold these output values in the cycle after reset: x=0, x_valid=0, frame_start=0, busy=0 and in_ready=1 (if areset has deasserted).
REQ-027 SHALL, on reset mid-word, discard the remaining bits and emit no frame_start for the aborted word.

Verification (WIDTH=8)
REQ-028 SHALL cover a single word: handshake of 0x01 at edge 0 -> frame_start in cycle 1 -> x = 1,0,0,0,0,0,0,0 with x_valid=1 in cycles 2..9 -> in cycle 10 IDLE, in_ready=1, busy=0.
REQ-029 SHALL cover back-to-back words: 0xA5 then 0x3C, with the second handshake on the last bit cycle of the first -> x = 1,0,1,0,0,1,0,1, then one frame_start cycle, then 0,0,1,1,1,1,0,0; total 18 cycles.
REQ-030 SHALL cover ignored input: in_valid held high with in_data changing every cycle during SHIFT of 0xF0 -> serialized bits still 0,0,0,0,1,1,1,1; next word accepted only on the last bit cycle.
REQ-031 SHALL cover reset mid-shift: 0xFF, areset=1 after 3 bits -> next cycle x_valid=0, busy=0; after release in_ready=1; a new word 0x80 gives frame_start, then bits 0x7 zeros followed by 1.
REQ-032 SHALL cover reset vs handshake: areset=1 and in_valid=1 on the same edge -> word not accepted, no frame_start, state IDLE.
REQ-033 SHALL cover end-to-end with the downstream complementer (frame_start as its reset): word 0x06 -> complement stream 0,1,0,1,1,1,1,1 (0xFA).
